counter_ctrl: RTL and testbench

Sequencing controller for the 4-bit enable counter. It generates prescaled `ctr_enable` ticks and issues `ctr_clear` pulses. It watches the counter's `count` output against a programmable terminal value and supports one-shot and auto-reload modes. It sits between the front-panel/CPU control strobes and the counter instance: the counter's `enable` is driven by `ctr_enable` and its `reset` by `ctr_clear`.

---
 rtl/counter_ctrl.sv | 145 ++++++++++++++
 tb/tb_counter_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
// -----------------------------------------------------------------------------
// counter_ctrl
//   Sequencing controller for the 4-bit enable counter. Generates prescaled
//   ctr_enable ticks, issues ctr_clear pulses to the counter's active-high
//   reset, and watches the counter's count feedback against a programmable
//   terminal value in one-shot or auto-reload mode.
//
//   Optional feature macro: COUNT_CTRL_WRAPCNT_EN
//     When defined, adds output wraps[7:0], a saturating count of
//     auto-reload terminal events.
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   asynchronous, active-low
//   start       in   strobe: run / resume
//   stop        in   strobe: pause
//   clear       in   strobe: abort to IDLE and zero the counter
//   mode        in   0 = one-shot, 1 = auto-reload (sampled continuously)
//   limit       in   terminal count (sampled continuously)
//   prescale    in   tick every prescale+1 RUN cycles
//   count       in   counter feedback
//   ctr_enable  out  combinational tick to the counter
//   ctr_clear   out  registered one-cycle clear pulse to the counter
//   busy        out  high in RUN or PAUSE
//   done        out  registered one-cycle terminal pulse
//   state       out  IDLE=00 RUN=01 PAUSE=10 DONE=11
//   wraps       out  (COUNT_CTRL_WRAPCNT_EN only) auto-reload event count
//
// Control strobes: start/stop/clear carry no handshake. Each is a level
// sampled on every rising edge; a high level for one cycle is one command.
// When several are high together, clear wins over stop, stop over the
// terminal condition, and the terminal condition over start.
// -----------------------------------------------------------------------------
module counter_ctrl #(
   parameter int COUNT_W    = 4,
   parameter int PRESCALE_W = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  clear,
   input  logic                  mode,
   input  logic [COUNT_W-1:0]    limit,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic [COUNT_W-1:0]    count,
   output logic                  ctr_enable,
   output logic                  ctr_clear,
   output logic                  busy,
   output logic                  done,
   output logic [1:0]            state
`ifdef COUNT_CTRL_WRAPCNT_EN
   ,
   output logic [7:0]            wraps
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   state_t                state_q;
   logic [PRESCALE_W-1:0] presc;

   logic in_run;
   logic tick_due;
   logic at_limit;
   logic term;

   assign in_run   = (state_q == S_RUN);
   // >= rather than == so that lowering prescale below the running presc
   // value fires on the next cycle instead of waiting for presc to wrap.
   assign tick_due = (presc >= prescale);
   assign at_limit = (count == limit);
   // During the ctr_clear cycle the count input is stale (the counter only
   // clears at the closing edge), so the terminal compare is masked.
   assign term     = in_run & at_limit & ~ctr_clear;

   assign ctr_enable = in_run & tick_due & ~at_limit & ~ctr_clear & ~stop & ~clear;
   assign busy       = (state_q == S_RUN) | (state_q == S_PAUSE);
   assign state      = state_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         presc     <= '0;
         ctr_clear <= 1'b0;
         done      <= 1'b0;
`ifdef COUNT_CTRL_WRAPCNT_EN
         wraps     <= 8'd0;
`endif
      end else begin
         // Pulses default low and are raised for exactly one cycle below.
         ctr_clear <= 1'b0;
         done      <= 1'b0;
         if (clear) begin
            state_q   <= S_IDLE;
            ctr_clear <= 1'b1;
            presc     <= '0;
`ifdef COUNT_CTRL_WRAPCNT_EN
            wraps     <= 8'd0;
`endif
         end else begin
            case (state_q)
               S_IDLE, S_DONE: begin
                  if (start) begin
                     state_q   <= S_RUN;
                     ctr_clear <= 1'b1;
                     presc     <= '0;
`ifdef COUNT_CTRL_WRAPCNT_EN
                     wraps     <= 8'd0;
`endif
                  end
               end
               S_RUN: begin
                  if (stop) begin
                     state_q <= S_PAUSE;   // presc held for resume
                  end else if (term) begin
                     done <= 1'b1;
                     if (!mode) begin
                        state_q <= S_DONE;
                     end else begin
                        ctr_clear <= 1'b1;
                        presc     <= '0;
`ifdef COUNT_CTRL_WRAPCNT_EN
                        if (wraps != 8'hFF) wraps <= wraps + 8'd1;
`endif
                     end
                  end else begin
                     presc <= tick_due ? '0 : presc + PRESCALE_W'(1);
                  end
               end
               S_PAUSE: begin
                  if (start) state_q <= S_RUN;   // resume without clearing
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_counter_ctrl.sv
module tb_counter_ctrl;

   localparam int COUNT_W    = 4;
   localparam int PRESCALE_W = 8;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   always #5 clock = ~clock;
   logic reset;

   logic                  start, stop, clear, mode;
   logic [COUNT_W-1:0]    limit;
   logic [PRESCALE_W-1:0] prescale;
   logic [COUNT_W-1:0]    cnt;
   logic                  ctr_enable, ctr_clear, busy, done;
   logic [1:0]            state;
`ifdef COUNT_CTRL_WRAPCNT_EN
   logic [7:0]            wraps;
`endif

   counter_ctrl #(.COUNT_W(COUNT_W), .PRESCALE_W(PRESCALE_W)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .clear      (clear),
      .mode       (mode),
      .limit      (limit),
      .prescale   (prescale),
      .count      (cnt),
      .ctr_enable (ctr_enable),
      .ctr_clear  (ctr_clear),
      .busy       (busy),
      .done       (done),
      .state      (state)
`ifdef COUNT_CTRL_WRAPCNT_EN
      ,
      .wraps      (wraps)
`endif
   );

   // Model of the 4-bit enable counter the controller drives.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)          cnt <= '0;
      else if (ctr_clear)  cnt <= '0;
      else if (ctr_enable) cnt <= cnt + 4'd1;
   end

   // ---------------- scoreboard ----------------
   int         n_cmp    = 0;
   int         n_err    = 0;
   int         tick_cnt = 0;
   int         tick_ref = 0;
   logic [0:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- driver ----------------
   // One clock cycle: strobes applied at the falling edge, outputs sampled
   // 1ns later, well before the next rising edge.
   task automatic run_cycle(input logic st, input logic sp, input logic cl);
      @(negedge clock);
      start = st;
      stop  = sp;
      clear = cl;
      #1;
      if (ctr_enable === 1'b1) tick_cnt++;
   endtask

   initial begin
      logic exp_d, exp_en;
      reset = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
      mode = 1'b0; limit = '0; prescale = '0;

      // ---- reset values ----
      repeat (2) @(negedge clock);
      #1;
      check("rst_state",   32'(state), 0);
      check("rst_busy",    32'(busy), 0);
      check("rst_done",    32'(done), 0);
      check("rst_clear",   32'(ctr_clear), 0);
      check("rst_enable",  32'(ctr_enable), 0);
`ifdef COUNT_CTRL_WRAPCNT_EN
      check("rst_wraps",   32'(wraps), 0);
`endif
      @(negedge clock);
      reset = 1'b1;

      // ---- one-shot: prescale=2 limit=3 ----
      prescale = 8'd2; limit = 4'd3; mode = 1'b0; tick_cnt = 0;
      run_cycle(1'b1, 1'b0, 1'b0);
      check("t1_idle_on_start", 32'(state), 0);
      run_cycle(1'b0, 1'b0, 1'b0);
      check("t1_run",        32'(state), 1);
      check("t1_clear",      32'(ctr_clear), 1);
      check("t1_busy",       32'(busy), 1);
      check("t1_no_tick",    32'(ctr_enable), 0);
      for (int i = 2; i <= 10; i++) exp_q.push_back((i == 3) || (i == 6) || (i == 9));
      for (int i = 2; i <= 10; i++) begin
         run_cycle(1'b0, 1'b0, 1'b0);
         check("t1_enable",    32'(ctr_enable), 32'(exp_q.pop_front()));
         check("t1_done_low",  32'(done), 0);
      end
      check("t1_count_at_T", 32'(cnt), 3);
      run_cycle(1'b0, 1'b0, 1'b0);
      check("t1_done",       32'(done), 1);
      check("t1_state_done", 32'(state), 3);
      check("t1_busy_low",   32'(busy), 0);
      check("t1_no_clear",   32'(ctr_clear), 0);
      check("t1_ticks",      32'(tick_cnt), 3);
      run_cycle(1'b0, 1'b0, 1'b0);
      check("t1_done_1cyc",  32'(done), 0);
      check("t1_hold_state", 32'(state), 3);
      check("t1_hold_count", 32'(cnt), 3);

      // ---- auto-reload: prescale=0 limit=5 ----
      prescale = 8'd0; limit = 4'd5; mode = 1'b1; tick_cnt = 0;
      run_cycle(1'b1, 1'b0, 1'b0);
      check("t2_from_done", 32'(state), 3);
      run_cycle(1'b0, 1'b0, 1'b0);
      check("t2_run",   32'(state), 1);
      check("t2_clear", 32'(ctr_clear), 1);
`ifdef COUNT_CTRL_WRAPCNT_EN
      check("t2_wraps0", 32'(wraps), 0);
`endif
      for (int j = 2; j <= 22; j++) begin
         run_cycle(1'b0, 1'b0, 1'b0);
         exp_d  = (j == 8) || (j == 15) || (j == 22);
         exp_en = !((j == 7) || (j == 8) || (j == 14) || (j == 15) || (j == 21) || (j == 22));
         check("t2_done",   32'(done), 32'(exp_d));
         check("t2_clear",  32'(ctr_clear), 32'(exp_d));
         check("t2_enable", 32'(ctr_enable), 32'(exp_en));
         check("t2_state",  32'(state), 1);
`ifdef COUNT_CTRL_WRAPCNT_EN
         if (exp_d) check("t2_wraps", 32'(wraps), (j == 8) ? 1 : (j == 15) ? 2 : 3);
`endif
      end
      check("t2_ticks", 32'(tick_cnt), 15);
      run_cycle(1'b0, 1'b0, 1'b1);
      check("t2_clear_gates_enable", 32'(ctr_enable), 0);
      run_cycle(1'b0, 1'b0, 1'b0);
      check("t2_idle",       32'(state), 0);
      check("t2_clr_pulse",  32'(ctr_clear), 1);
      check("t2_no_done",    32'(done), 0);
      check("t2_busy_low",   32'(busy), 0);
`ifdef COUNT_CTRL_WRAPCNT_EN
      check("t2_wraps_clr",  32'(wraps), 0);
`endif

      // ---- pause / resume: prescale=2, stop at count=2 presc=1 ----
      prescale = 8'd2; limit = 4'd9; mode = 1'b0;
      run_cycle(1'b1, 1'b0, 1'b0);
      repeat (7) run_cycle(1'b0, 1'b0, 1'b0);
      check("t3_count_before_stop", 32'(cnt), 2);
      tick_ref = tick_cnt;
      run_cycle(1'b0, 1'b1, 1'b0);
      check("t3_stop_cycle_enable", 32'(ctr_enable), 0);
      run_cycle(1'b0, 1'b0, 1'b0);
      check("t3_pause", 32'(state), 2);
      check("t3_busy",  32'(busy), 1);
      repeat (2) run_cycle(1'b0, 1'b0, 1'b0);
      run_cycle(1'b1, 1'b0, 1'b0);
      check("t3_still_pause",  32'(state), 2);
      check("t3_no_pause_tick", 32'(tick_cnt), 32'(tick_ref));
      run_cycle(1'b0, 1'b0, 1'b0);
      check("t3_resumed",      32'(state), 1);
      check("t3_no_clear",     32'(ctr_clear), 0);
      check("t3_held_count",   32'(cnt), 2);
      check("t3_no_tick_yet",  32'(ctr_enable), 0);
      run_cycle(1'b0, 1'b0, 1'b0);
      check("t3_resume_tick",  32'(ctr_enable), 1);

      // ---- clear + stop together in RUN ----
      run_cycle(1'b0, 1'b1, 1'b1);
      check("t4_count_3",   32'(cnt), 3);
      run_cycle(1'b0, 1'b0, 1'b0);
      check("t4_idle",      32'(state), 0);
      check("t4_clear",     32'(ctr_clear), 1);
      check("t4_busy",      32'(busy), 0);

      // ---- stop while terminal condition true ----
      prescale = 8'd0; limit = 4'd2; mode = 1'b0;
      run_cycle(1'b1, 1'b0, 1'b0);
      repeat (3) run_cycle(1'b0, 1'b0, 1'b0);
      run_cycle(1'b0, 1'b1, 1'b0);
      check("t5_count_at_T", 32'(cnt), 2);
      run_cycle(1'b0, 1'b0, 1'b0);
      check("t5_pause",      32'(state), 2);
      check("t5_no_done",    32'(done), 0);
      run_cycle(1'b1, 1'b0, 1'b0);
      run_cycle(1'b0, 1'b0, 1'b0);
      check("t5_run",        32'(state), 1);
      check("t5_done_low",   32'(done), 0);
      run_cycle(1'b0, 1'b0, 1'b0);
      check("t5_done",       32'(done), 1);
      check("t5_state_done", 32'(state), 3);

      // ---- limit = 0: terminal with zero ticks ----
      limit = 4'd0; tick_cnt = 0;
      run_cycle(1'b1, 1'b0, 1'b0);
      run_cycle(1'b0, 1'b0, 1'b0);
      check("t6_clear",   32'(ctr_clear), 1);
      check("t6_enable0", 32'(ctr_enable), 0);
      run_cycle(1'b0, 1'b0, 1'b0);
      check("t6_run",     32'(state), 1);
      check("t6_enable1", 32'(ctr_enable), 0);
      check("t6_count",   32'(cnt), 0);
      run_cycle(1'b0, 1'b0, 1'b0);
      check("t6_done",    32'(done), 1);
      check("t6_state",   32'(state), 3);
      check("t6_ticks",   32'(tick_cnt), 0);

      // ---- limit lowered 9 -> 1 at count=4: wraps through 15 -> 0 -> 1 ----
      limit = 4'd9; tick_cnt = 0;
      run_cycle(1'b1, 1'b0, 1'b0);
      repeat (5) run_cycle(1'b0, 1'b0, 1'b0);
      run_cycle(1'b0, 1'b0, 1'b0);
      check("t7_count4", 32'(cnt), 4);
      limit = 4'd1;
      repeat (11) run_cycle(1'b0, 1'b0, 1'b0);
      check("t7_count15", 32'(cnt), 15);
      run_cycle(1'b0, 1'b0, 1'b0);
      check("t7_wrapped",    32'(cnt), 0);
      check("t7_wrap_tick",  32'(ctr_enable), 1);
      run_cycle(1'b0, 1'b0, 1'b0);
      check("t7_count1",     32'(cnt), 1);
      check("t7_no_tick_T",  32'(ctr_enable), 0);
      check("t7_done_low",   32'(done), 0);
      run_cycle(1'b0, 1'b0, 1'b0);
      check("t7_done",       32'(done), 1);
      check("t7_state",      32'(state), 3);
      check("t7_ticks",      32'(tick_cnt), 17);

      // ---- async reset in the middle of RUN ----
      prescale = 8'd3; limit = 4'd5; mode = 1'b1;
      run_cycle(1'b1, 1'b0, 1'b0);
      run_cycle(1'b0, 1'b0, 1'b0);
      check("t8_clear_before", 32'(ctr_clear), 1);
      #2 reset = 1'b0;
      #1;
      check("t8_rst_state",  32'(state), 0);
      check("t8_rst_clear",  32'(ctr_clear), 0);
      check("t8_rst_busy",   32'(busy), 0);
      check("t8_rst_done",   32'(done), 0);
      check("t8_rst_enable", 32'(ctr_enable), 0);
      @(negedge clock);
      reset = 1'b1;
      run_cycle(1'b1, 1'b0, 1'b0);
      check("t8_idle", 32'(state), 0);
      run_cycle(1'b0, 1'b0, 1'b0);
      check("t8_run",      32'(state), 1);
      check("t8_clear",    32'(ctr_clear), 1);
      check("t8_enable_a", 32'(ctr_enable), 0);
      run_cycle(1'b0, 1'b0, 1'b0);
      check("t8_enable_b", 32'(ctr_enable), 0);
      run_cycle(1'b0, 1'b0, 1'b0);
      check("t8_enable_c", 32'(ctr_enable), 0);
      run_cycle(1'b0, 1'b0, 1'b0);
      check("t8_first_tick", 32'(ctr_enable), 1);

      // ---- report ----
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
